// File: rtl/trigger_capture_if.sv
// Signal bundle between the sample source / read-out bridge (master) and trigger_capture (slave).
// force_trig is present only when TRIG_FORCE_EN is defined.
interface trigger_capture_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              arm;
    logic [DATA_W-1:0] trig_level;
    logic [ADDR_W-1:0] pretrig;
`ifdef TRIG_FORCE_EN
    logic              force_trig;
`endif
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;

    modport master (
        output sample_in, sample_valid, arm, trig_level, pretrig, rd_en, rd_addr,
`ifdef TRIG_FORCE_EN
        output force_trig,
`endif
        input  rd_data, rd_valid, busy, done
    );

    modport slave (
        input  sample_in, sample_valid, arm, trig_level, pretrig, rd_en, rd_addr,
`ifdef TRIG_FORCE_EN
        input  force_trig,
`endif
        output rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/trigger_capture.sv
// Pre/post-trigger capture into a circular buffer, frozen afterwards for random-access read-out.
// Define TRIG_FORCE_EN to add force_trig, which triggers on a valid WAIT_TRIG sample regardless of level.
module trigger_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    trigger_capture_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] pre_lat;
    logic [ADDR_W-1:0] rd_phys;
    logic [DATA_W-1:0] level_lat;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_next;
    logic [ADDR_W:0]   post_len;
    logic              wr_en;
    logic              trig_hit;
    logic              rd_fire;
    logic              busy_q;
    logic              done_q;
    logic              rd_valid_q;

    // prev starts at all ones, so a level crossing can never fire on the first sample
    always_comb begin
        wr_en    = bus.sample_valid && (state inside {PRE, WAIT_TRIG, POST});
        cnt_next = cnt + 1'b1;
        post_len = DEPTH_CNT - {1'b0, pre_lat};
        trig_hit = (prev < level_lat) && (bus.sample_in >= level_lat);
`ifdef TRIG_FORCE_EN
        trig_hit = trig_hit || bus.force_trig;
`endif
        rd_fire  = bus.rd_en && (state == DONE);
        rd_phys  = trig_addr - pre_lat + bus.rd_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wptr      <= '0;
            cnt       <= '0;
            trig_addr <= '0;
            pre_lat   <= '0;
            level_lat <= '0;
            prev      <= '1;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
                prev <= bus.sample_in;
            end
            case (state)
                IDLE, DONE: begin
                    // pretrig is ADDR_W bits wide, so it can never exceed DEPTH-1
                    if (bus.arm) begin
                        level_lat <= bus.trig_level;
                        pre_lat   <= bus.pretrig;
                        wptr      <= '0;
                        cnt       <= '0;
                        prev      <= '1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state     <= (bus.pretrig == '0) ? WAIT_TRIG : PRE;
                    end
                end
                PRE: begin
                    if (bus.sample_valid) begin
                        if (cnt_next == {1'b0, pre_lat}) begin
                            cnt   <= '0;
                            state <= WAIT_TRIG;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (bus.sample_valid && trig_hit) begin
                        trig_addr <= wptr;
                        if (pre_lat == '1) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt   <= {{ADDR_W{1'b0}}, 1'b1};
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    if (bus.sample_valid) begin
                        if (cnt_next == post_len) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= bus.sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= mem[rd_phys];
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_trigger_capture.sv
// Randomized self-checking bench for trigger_capture (DEPTH=16) against a sample-list reference model.
// Define TRIG_FORCE_EN for both bench and design to exercise the forced trigger.
module tb_trigger_capture;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;

    trigger_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    trigger_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q[$];
    bit qf[$];
    int qc[$];
    int exp_data[DEPTH];

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then advance to the next falling edge
    task automatic applyStimulus(input bit valid, input int sample, input bit arm_in, input int level,
                                 input int pre, input bit force_in, input bit rd_en_in, input int rd_addr_in);
        bus.sample_valid = valid;
        bus.sample_in    = DATA_W'(sample);
        bus.arm          = arm_in;
        bus.trig_level   = DATA_W'(level);
        bus.pretrig      = ADDR_W'(pre);
`ifdef TRIG_FORCE_EN
        bus.force_trig   = force_in;
`else
        if (force_in) bus.sample_in = DATA_W'(sample);
`endif
        bus.rd_en        = rd_en_in;
        bus.rd_addr      = ADDR_W'(rd_addr_in);
        @(negedge clk);
    endtask

    // q holds every valid sample offered after arm; the first pre are history, then the first
    // crossing (or force) at or after index pre triggers, and DEPTH-pre samples end the capture
    function automatic void model_capture(input int level, input int pre, output int trig_idx, output int last_idx);
        int prev;
        prev     = 65535;
        trig_idx = -1;
        last_idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (i >= pre && ((prev < level && q[i] >= level) || qf[i])) begin
                trig_idx = i;
                break;
            end
            prev = q[i];
        end
        if (trig_idx >= 0) last_idx = trig_idx + DEPTH - pre - 1;
    endfunction

    task automatic read_back(input string name, input int pre, input int first_exp, input int trig_exp);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 65535), 1'b0, 0, 0, 1'b0, 1'b1, i);
            checkOutput($sformatf("%s_rd_valid%0d", name, i), bus.rd_valid, 1);
            checkOutput($sformatf("%s_rd_data%0d", name, i), bus.rd_data, exp_data[i]);
            if (i == 0 && first_exp >= 0) checkOutput({name, "_oldest"}, bus.rd_data, first_exp);
            if (i == pre && trig_exp >= 0) checkOutput({name, "_trig_sample"}, bus.rd_data, trig_exp);
        end
        applyStimulus(1'b1, $urandom_range(0, 65535), 1'b0, 0, 0, 1'b0, 1'b0, 0);
        checkOutput({name, "_rd_valid_off"}, bus.rd_valid, 0);
        checkOutput({name, "_rd_data_hold"}, bus.rd_data, exp_data[DEPTH-1]);
    endtask

    // mode 0: gapless ramp, 1: ramp with valid every other cycle, 2: random data and valid
    task automatic run_capture(input string name, input int level, input int pre, input int mode,
                               input int force_val, input int first_exp, input int trig_exp);
        int ramp;
        int done_cyc;
        int trig_idx;
        int last_idx;
        int val;
        bit valid;
        bit frc;
        q.delete();
        qf.delete();
        qc.delete();
        applyStimulus(1'b1, 0, 1'b1, level, pre, 1'b0, 1'b0, 0);
        checkOutput({name, "_busy_on_arm"}, bus.busy, 1);
        checkOutput({name, "_done_on_arm"}, bus.done, 0);
        ramp     = 1;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            case (mode)
                0:       valid = 1'b1;
                1:       valid = (cyc % 2) == 1;
                default: valid = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2) val = $urandom_range(0, 255);
            else           val = valid ? ramp : $urandom_range(0, 65535);
            frc = 1'b0;
`ifdef TRIG_FORCE_EN
            if (force_val >= 0) frc = valid && (val == force_val);
            else if (mode == 2) frc = ($urandom_range(0, 29) == 0);
`endif
            if (valid) begin
                q.push_back(val);
                qf.push_back(frc);
                qc.push_back(cyc);
                ramp++;
            end
            applyStimulus(valid, val, $urandom_range(0, 19) == 0, $urandom_range(1, 65535),
                          $urandom_range(0, DEPTH-1), frc, 1'b0, 0);
        end
        model_capture(level, pre, trig_idx, last_idx);
        if (trig_idx < 0 || last_idx >= q.size()) begin
            checkOutput({name, "_done_seen"}, (done_cyc >= 0) ? 1 : 0, 0);
            return;
        end
        checkOutput({name, "_done_cycle"}, done_cyc, qc[last_idx] + 1);
        if (done_cyc < 0) return;
        checkOutput({name, "_busy_at_done"}, bus.busy, 0);
        for (int i = 0; i < DEPTH; i++) exp_data[i] = q[trig_idx - pre + i];
        read_back(name, pre, first_exp, trig_exp);
    endtask

    initial begin
        $display("[TB] trigger_capture bench, DEPTH=%0d", DEPTH);
        reset = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_rd_valid", bus.rd_valid, 0);
        checkOutput("reset_rd_data", bus.rd_data, 0);
        reset = 1'b0;

        applyStimulus(1'b1, 7, 1'b0, 0, 0, 1'b0, 1'b1, 3);
        checkOutput("idle_rd_valid", bus.rd_valid, 0);
        checkOutput("idle_rd_data", bus.rd_data, 0);

        run_capture("pre4",  100, 4,  0, -1, 96,  100);
        run_capture("pre0",  100, 0,  0, -1, 100, 100);
        run_capture("pre15", 100, 15, 0, -1, 85,  100);
        run_capture("gaps",  100, 4,  1, -1, 96,  100);
`ifdef TRIG_FORCE_EN
        run_capture("force", 1000, 4, 0, 50, 46, 50);
`endif
        for (int r = 0; r < 25; r++) begin
            run_capture($sformatf("rand%0d", r), $urandom_range(1, 200), $urandom_range(0, DEPTH-1), 2, -1, -1, -1);
        end

        // level 0 never triggers; the arm at sample 20 would complete by ~64 if wrongly accepted
        applyStimulus(1'b1, 0, 1'b1, 0, 4, 1'b0, 1'b0, 0);
        for (int c = 1; c < 80; c++) begin
            applyStimulus(1'b1, c, c == 20, 50, 2, 1'b0, 1'b1, 0);
        end
        checkOutput("lvl0_busy", bus.busy, 1);
        checkOutput("lvl0_done", bus.done, 0);
        checkOutput("lvl0_rd_valid", bus.rd_valid, 0);

        reset = 1'b1;
        applyStimulus(1'b1, 80, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        reset = 1'b0;
        applyStimulus(1'b1, 81, 1'b0, 0, 0, 1'b0, 1'b1, 5);
        checkOutput("post_rst_rd_valid", bus.rd_valid, 0);
        checkOutput("post_rst_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
